// File: rtl/mult32_seq.sv
// ---------------------------------------------------------------------------
// mult32_seq -- sequential shift-add multiplier (MIPS mult/multu style).
//
// One multiplier bit is processed per clock. A result is ready WIDTH+1 edges
// after the start is accepted, and the DONE state lasts for one cycle.
//
// Configuration macro:
//   MULT32_SEQ_SIGNED_EN  defined   : is_signed=1 selects a two's-complement
//                                     multiply (magnitudes, then negate).
//                         undefined : every operation is unsigned. The
//                                     is_signed port is kept but ignored.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   begin a multiply (only sampled in IDLE)
//   a, b       in   WIDTH-bit operands, captured when start is accepted
//   is_signed  in   1 = signed (mult), 0 = unsigned (multu)
//   busy       out  high in RUN (hi/lo invalid)
//   done       out  one-cycle pulse in DONE (hi/lo valid)
//   hi, lo     out  upper/lower halves of the 2*WIDTH-bit product. They hold
//                   until the next accepted start.
// ---------------------------------------------------------------------------
module mult32_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_acc_final;
    logic [WIDTH-1:0]   w_op_a;
    logic [WIDTH-1:0]   w_op_b;

`ifdef MULT32_SEQ_SIGNED_EN
    logic r_neg;
    logic w_neg;

    // Signed mode works on magnitudes. The most negative value negates to
    // itself, and that bit pattern read as unsigned is 2^(WIDTH-1).
    always_comb begin
        w_op_a = (is_signed && a[WIDTH-1]) ? -a : a;
        w_op_b = (is_signed && b[WIDTH-1]) ? -b : b;
        w_neg  = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
    end

    assign w_acc_final = r_neg ? -w_acc_next : w_acc_next;
`else
    logic w_unused_sign;

    assign w_unused_sign = is_signed;
    assign w_op_a        = a;
    assign w_op_b        = b;
    assign w_acc_final   = w_acc_next;
`endif

    // One shift-add step. The (WIDTH+1)-bit sum keeps the carry, and the
    // carry is shifted back into the top of the accumulator.
    always_comb begin
        w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_mplier[0] ? {1'b0, r_mcand} : '0);
        w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef MULT32_SEQ_SIGNED_EN
            r_neg    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= w_op_a;
                        r_mplier <= w_op_b;
`ifdef MULT32_SEQ_SIGNED_EN
                        r_neg    <= w_neg;
`endif
                        r_acc    <= '0;
                        r_cnt    <= CW'(WIDTH);
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_acc   <= w_acc_final;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_acc   <= w_acc_next;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_acc[2*WIDTH-1:WIDTH];
    assign lo   = r_acc[WIDTH-1:0];

endmodule

// File: doc/mult32_seq.md
MULT32_SEQ -- requirements
Module: mult32_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; the result is 2*WIDTH bits.
REQ-002 SHALL have port clk  input  1  single clock, rising-edge active.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  multiplicand; captured at start acceptance.
REQ-006 SHALL have port b  input  WIDTH  multiplier; captured at start acceptance.
REQ-007 SHALL have port is_signed  input  1  1 = two's-complement multiply (MIPS mult), 0 = unsigned (multu); captured at start acceptance.
REQ-008 SHALL have port busy  output  1  high while the operation is in progress (RUN state).
REQ-009 SHALL have port done  output  1  one-cycle pulse when hi/lo become valid.
REQ-010 SHALL have port hi  output  WIDTH  upper half of the product.
REQ-011 SHALL have port lo  output  WIDTH  lower half of the product.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-013 SHALL, on a clock edge in IDLE with start=1, capture a, b and is_signed, clear the accumulator, load the bit counter with WIDTH and enter RUN.
REQ-014 SHALL process one multiplier bit per cycle in RUN: if the LSB is set, add the multiplicand into the upper accumulator half with a (WIDTH+1)-bit carry; then shift the {carry, accumulator} pair right by 1; then decrement the counter.
REQ-015 SHALL go from RUN to DONE on the edge that completes the WIDTH-th iteration.
REQ-016 SHALL take exactly WIDTH+1 edges from the accept edge k to DONE: the DONE state, with done=1 and hi/lo valid, holds after edge k+WIDTH; after edge k+WIDTH+1 the state is IDLE and done=0.
REQ-017 SHALL, in signed mode, multiply the magnitudes |a| and |b|, and 2's-complement negate the 2*WIDTH result on entry to DONE when the sign bits of a and b differ.
REQ-018 SHALL treat the most negative operand (0x80000000) correctly; its magnitude is 2^31 as an unsigned WIDTH-bit value.
REQ-019 SHALL hold hi/lo stable from DONE until the next accepted start.
REQ-020 SHALL leave hi/lo undefined for observers during RUN; busy=1 marks them invalid.
REQ-021 SHALL ignore start while in RUN or DONE; no restart and no corruption of the operation in progress.
REQ-022 SHALL assert busy exactly in RUN and done exactly in DONE.
REQ-023 SHALL produce a zero result when either operand is 0, with the same latency as any other operand pair.

Reset
REQ-024 SHALL, on reset_n=0 at any time (including mid-RUN), immediately force: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, with captured operands cleared.
REQ-025 SHALL accept a start on the first rising edge after reset_n deasserts.

Configuration
REQ-026 SHALL recognise the macro MULT32_SEQ_SIGNED_EN.
REQ-027 SHALL, when MULT32_SEQ_SIGNED_EN is defined, honour is_signed as in REQ-017.
REQ-028 SHALL, when MULT32_SEQ_SIGNED_EN is undefined, keep the is_signed port but ignore it, so every operation is unsigned; the magnitude/negation logic SHALL be absent.

Verification
REQ-029 SHALL cover: a=3, b=5, unsigned -> done after WIDTH+1 edges, hi=0x00000000, lo=0x0000000F.
REQ-030 SHALL cover: a=0xFFFFFFFF, b=0xFFFFFFFF, unsigned -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 SHALL cover, with SIGNED_EN defined: a=0xFFFFFFFE (-2), b=3, signed -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; and a=0x80000000, b=0x80000000, signed -> hi=0x40000000, lo=0.
REQ-032 SHALL cover: start with a=7, b=9, then start with a=1, b=1 at cycle 5 of RUN -> second start ignored, result lo=63, busy stays 1 until DONE.
REQ-033 SHALL cover: reset_n pulsed low at cycle 10 of RUN -> busy=0, done=0, hi=lo=0 immediately; a new start with a=2, b=4 then gives lo=8.
REQ-034 SHALL cover: back-to-back starts (start held at 1) -> a new operation is accepted on the edge after DONE returns to IDLE, and done pulses exactly once per operation.
